decryption_sequencer: RTL and testbench

Per-message controller for the decryption datapath, on the system clock between the input demux and the three engines (caesar, scytale, zigzag). It latches the algorithm select from the register file at message start and steers input bytes to the selected engine. It tracks the engine's processing and output phases, drives the global busy and the output-mux select, and reports per-message completion and protocol errors as single-cycle pulses.

---
 rtl/decryption_sequencer_if.sv | 24 ++
 rtl/decryption_sequencer.sv | 90 +++++++++
 tb/tb_decryption_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decryption_sequencer_if.sv
// decryption_sequencer_if: byte-input, engine-steering and status bundle for the decryption sequencer
//   master: sequencer view (takes select/valid_i/data_i/eng_*_i, drives eng_*_o/sel_o/busy/msg_*)
//   slave : environment view (regfile, input demux, engines, status consumers)
interface decryption_sequencer_if #(parameter int SYS_DWIDTH = 8);
  logic [1:0] select;
  logic valid_i;
  logic [SYS_DWIDTH-1:0] data_i;
  logic [2:0] eng_valid_o;
  logic [SYS_DWIDTH-1:0] eng_data_o;
  logic [2:0] eng_busy_i;
  logic [2:0] eng_valid_i;
  logic [1:0] sel_o;
  logic busy;
  logic msg_done;
  logic msg_err;
  modport master(
    input select, valid_i, data_i, eng_busy_i, eng_valid_i,
    output eng_valid_o, eng_data_o, sel_o, busy, msg_done, msg_err
  );
  modport slave(
    output select, valid_i, data_i, eng_busy_i, eng_valid_i,
    input eng_valid_o, eng_data_o, sel_o, busy, msg_done, msg_err
  );
endinterface

// File: rtl/decryption_sequencer.sv
// decryption_sequencer: per-message controller steering input bytes to the caesar/scytale/zigzag engines
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : decryption_sequencer_if.master
//           select (algorithm, latched at message start), valid_i/data_i (input bytes),
//           eng_valid_o/eng_data_o (one-hot forwarded byte), eng_busy_i/eng_valid_i (engine status),
//           sel_o (output mux select), busy, msg_done/msg_err (one-cycle pulses)
//   DECRYPT_SEQ_TIMEOUT_EN: when defined, WAIT aborts with msg_err after TIMEOUT cycles
module decryption_sequencer #(
  parameter int SYS_DWIDTH = 8,
  parameter int MAX_LEN = 50,
  parameter logic [SYS_DWIDTH-1:0] END_CHAR = 8'hFA
`ifdef DECRYPT_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input logic clk,
  input logic rst_n,
  decryption_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, FLUSH} state_t;
  localparam int LW = $clog2(MAX_LEN + 1);
  state_t state, state_n;
  logic [LW-1:0] len, len_n;
  logic [1:0] sel, sel_n;
  logic [2:0] eng_valid, eng_valid_n;
  logic [SYS_DWIDTH-1:0] eng_data;
  logic busy, done, err, done_n, err_n;
  logic is_end, full, eng_v, eng_b, fwd, tmo;
  assign is_end = bus.data_i == END_CHAR;
  // a further non-terminator byte would make the message MAX_LEN long with no room for the terminator
  assign full = len == LW'(MAX_LEN - 1);
  assign eng_v = bus.eng_valid_i[sel];
  assign eng_b = bus.eng_busy_i[sel];
`ifdef DECRYPT_SEQ_TIMEOUT_EN
  logic [9:0] cnt;
  // held at zero outside WAIT, so it is already clear on WAIT entry
  always_ff @(posedge clk)
    cnt <= (!rst_n || state != WAIT) ? '0 : cnt + 1'b1;
  assign tmo = state == WAIT && cnt == 10'(TIMEOUT);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      sel <= '0;
      eng_valid <= '0;
      eng_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      sel <= sel_n;
      eng_valid <= eng_valid_n;
      if (fwd) eng_data <= bus.data_i;
      busy <= state_n != IDLE;
      done <= done_n;
      err <= err_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.valid_i && bus.select != 2'd3) state_n = is_end ? WAIT : LOAD;
      LOAD: if (bus.valid_i) state_n = is_end ? WAIT : (full ? FLUSH : LOAD);
      FLUSH: if (bus.valid_i && is_end) state_n = IDLE;
      WAIT: state_n = eng_v ? DRAIN : (tmo ? IDLE : WAIT);
      DRAIN: if (!eng_v && !eng_b) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    fwd = bus.valid_i && ((state == IDLE && bus.select != 2'd3) || (state == LOAD && (is_end || !full)));
    sel_n = (state == IDLE && fwd) ? bus.select : sel;
    len_n = fwd ? (state == IDLE ? LW'(1) : len + 1'b1) : len;
    eng_valid_n = fwd ? 3'(3'b001 << sel_n) : 3'b000;
    err_n = tmo || (bus.valid_i && ((state == IDLE && bus.select == 2'd3) ||
            (state == LOAD && !is_end && full) || state == WAIT || state == DRAIN));
    done_n = state == DRAIN && !eng_v && !eng_b;
  end
  assign bus.eng_valid_o = eng_valid;
  assign bus.eng_data_o = eng_data;
  assign bus.sel_o = sel;
  assign bus.busy = busy;
  assign bus.msg_done = done;
  assign bus.msg_err = err;
endmodule

// File: tb/tb_decryption_sequencer.sv
// tb_decryption_sequencer: randomized self-checking bench for decryption_sequencer
module tb_decryption_sequencer;
  localparam logic [7:0] EC = 8'hFA;
  localparam int ML = 50;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  decryption_sequencer_if bus();
  decryption_sequencer dut(.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    return (b == EC) ? 8'h00 : b;
  endfunction

  // randomize the engine status bits that belong to engines other than s
  task automatic noise(input int s);
    logic [2:0] m;
    m = 3'(3'b001 << s);
    bus.eng_valid_i = (3'($urandom) & ~m) | (bus.eng_valid_i & m);
    bus.eng_busy_i = 3'($urandom) & ~m;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [2:0] exp_ev, input logic exp_err, input string tag);
    bus.valid_i = 1'b1;
    bus.data_i = b;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    checks++;
    if (bus.eng_valid_o !== exp_ev || (exp_ev != 3'b000 && bus.eng_data_o !== b)) begin
      errors++;
      $display("FAIL %s fwd: got %b/%h want %b/%h", tag, bus.eng_valid_o, bus.eng_data_o, exp_ev, b);
    end
    checks++;
    if (bus.msg_err !== exp_err || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL %s pulses: got err=%b done=%b want err=%b done=0", tag, bus.msg_err, bus.msg_done, exp_err);
    end
  endtask

  task automatic send_msg(input int s, input int n);
    bus.select = 2'(s);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL msg_start busy: got %b want 0", bus.busy);
    end
    for (int i = 0; i < n; i++) begin
      send_byte(rnd_byte(), 3'(3'b001 << s), 1'b0, "load");
      if (i == 0) bus.select = 2'($urandom);
    end
    send_byte(EC, 3'(3'b001 << s), 1'b0, "term");
    bus.select = 2'($urandom);
    checks++;
    if (bus.busy !== 1'b1 || bus.sel_o !== 2'(s)) begin
      errors++;
      $display("FAIL msg_loaded: got busy=%b sel=%0d want busy=1 sel=%0d", bus.busy, bus.sel_o, s);
    end
  endtask

  task automatic run_engine(input int s, input int delay, input int burst);
    for (int i = 0; i < delay; i++) begin noise(s); @(posedge clk); #1; end
    checks++;
    if (bus.busy !== 1'b1 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL wait: got busy=%b done=%b want 1/0", bus.busy, bus.msg_done);
    end
    for (int i = 0; i < burst; i++) begin noise(s); bus.eng_valid_i[s] = 1'b1; @(posedge clk); #1; end
    checks++;
    if (bus.busy !== 1'b1 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL drain: got busy=%b done=%b want 1/0", bus.busy, bus.msg_done);
    end
    noise(s);
    bus.eng_valid_i[s] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.msg_done !== 1'b1 || bus.busy !== 1'b0 || bus.sel_o !== 2'(s) || bus.msg_err !== 1'b0) begin
      errors++;
      $display("FAIL done: got done=%b busy=%b sel=%0d err=%b want 1/0/%0d/0", bus.msg_done, bus.busy, bus.sel_o, bus.msg_err, s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i = 8'h41;
    repeat (2) @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    checks++;
    if (bus.eng_valid_o !== 3'b000 || bus.eng_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset eng: got %b/%h want 000/00", bus.eng_valid_o, bus.eng_data_o);
    end
    checks++;
    if (bus.sel_o !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset status: got sel=%0d busy=%b want 0/0", bus.sel_o, bus.busy);
    end
    checks++;
    if (bus.msg_done !== 1'b0 || bus.msg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset pulses: got done=%b err=%b want 0/0", bus.msg_done, bus.msg_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_invalid_select();
    bus.select = 2'd3;
    send_byte(8'h41, 3'b000, 1'b1, "badsel");
    checks++;
    if (bus.busy !== 1'b0 || bus.eng_data_o !== 8'h00) begin
      errors++;
      $display("FAIL badsel state: got busy=%b data=%h want 0/00", bus.busy, bus.eng_data_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.msg_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL badsel pulse width: got err=%b busy=%b want 0/0", bus.msg_err, bus.busy);
    end
  endtask

  task automatic test_basic();
    bus.select = 2'd0;
    send_byte(8'h41, 3'b001, 1'b0, "basic0");
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic busy rise: got %b want 1", bus.busy);
    end
    send_byte(8'h42, 3'b001, 1'b0, "basic1");
    send_byte(EC, 3'b001, 1'b0, "basic2");
    run_engine(0, 3, 2);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      int s;
      s = $urandom_range(0, 2);
      send_msg(s, $urandom_range(0, 8));
      run_engine(s, $urandom_range(0, 5), $urandom_range(1, 4));
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b, last;
    last = 8'h00;
    bus.select = 2'd2;
    for (int i = 1; i <= ML; i++) begin
      b = rnd_byte();
      send_byte(b, (i < ML) ? 3'b100 : 3'b000, i == ML, "ovf");
      if (i < ML) last = b;
    end
    checks++;
    if (bus.eng_data_o !== last || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf hold: got data=%h busy=%b want %h/1", bus.eng_data_o, bus.busy, last);
    end
    for (int i = 0; i < 3; i++) send_byte(rnd_byte(), 3'b000, 1'b0, "flush");
    send_byte(EC, 3'b000, 1'b0, "flush_end");
    checks++;
    if (bus.busy !== 1'b0 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL flush exit: got busy=%b done=%b want 0/0", bus.busy, bus.msg_done);
    end
    for (int i = 1; i < ML; i++) send_byte(rnd_byte(), 3'b100, 1'b0, "maxlen");
    send_byte(EC, 3'b100, 1'b0, "maxlen_term");
    run_engine(2, 2, 1);
  endtask

  task automatic test_drain_err();
    int s;
    s = $urandom_range(0, 2);
    send_msg(s, 2);
    noise(s);
    bus.eng_valid_i[s] = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h33, 3'b000, 1'b1, "drain_byte");
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_byte busy: got %b want 1", bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.msg_err !== 1'b0 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL drain_byte after: got err=%b done=%b want 0/0", bus.msg_err, bus.msg_done);
    end
    bus.eng_valid_i[s] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.msg_done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_byte done: got done=%b busy=%b want 1/0", bus.msg_done, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    bus.eng_valid_i = 3'b000;
    bus.eng_busy_i = 3'b000;
    send_msg(1, 2);
`ifdef DECRYPT_SEQ_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 2000 && n == 0; i++) begin
      noise(1);
      @(posedge clk); #1;
      if (bus.msg_err === 1'b1) n = i;
    end
    checks++;
    if (n != 1024 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got err after %0d cycles busy=%b want 1024/0", n, bus.busy);
    end
`else
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      noise(1);
      @(posedge clk); #1;
      if (bus.busy !== 1'b1 || bus.msg_err !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL no_timeout: got %0d bad cycles want 0", n);
    end
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.eng_valid_i = 3'b000;
    bus.eng_busy_i = 3'b000;
  endtask

  task automatic test_reset_mid();
    bus.select = 2'd2;
    for (int i = 0; i < 3; i++) send_byte(rnd_byte(), 3'b100, 1'b0, "mid");
    rst_n = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i = rnd_byte();
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    checks++;
    if (bus.eng_valid_o !== 3'b000 || bus.eng_data_o !== 8'h00 || bus.sel_o !== 2'd0 || bus.busy !== 1'b0 ||
        bus.msg_done !== 1'b0 || bus.msg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got ev=%b d=%h sel=%0d busy=%b done=%b err=%b want all 0",
               bus.eng_valid_o, bus.eng_data_o, bus.sel_o, bus.busy, bus.msg_done, bus.msg_err);
    end
    send_msg(2, $urandom_range(1, 6));
    run_engine(2, $urandom_range(0, 4), $urandom_range(1, 3));
  endtask

  initial begin
    bus.select = 2'd0;
    bus.valid_i = 1'b0;
    bus.data_i = 8'h00;
    bus.eng_valid_i = 3'b000;
    bus.eng_busy_i = 3'b000;
    test_reset();
    test_invalid_select();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_drain_err();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
